// File: rtl/eth_tx_arbiter_pkg.sv
// Shared definitions for the Ethernet TX path arbiter: state encoding, requester
// indices and parameter defaults.
package eth_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StGrant = 2'd1,
        StSend  = 2'd2,
        StIfg   = 2'd3
    } arb_state_e;

    localparam int unsigned IfgCyclesDefault    = 12;
    localparam int unsigned StartTimeoutDefault = 1024;

    localparam logic ReqArp = 1'b0;
    localparam logic ReqUdp = 1'b1;

    function automatic logic [1:0] idx_to_onehot(input logic idx);
        return (idx == ReqUdp) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/eth_tx_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick: on a tie the requester not served last wins.
module rr_arb2
    import eth_tx_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] gnt_o,
    output logic       win_o
);

    always_comb begin
        win_o = ReqArp;
        gnt_o = 2'b00;
        if (req_i == 2'b11) begin
            win_o = ~last_i;
        end else if (req_i[ReqUdp]) begin
            win_o = ReqUdp;
        end
        if (req_i != 2'b00) begin
            gnt_o = idx_to_onehot(win_o);
        end
    end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Shares the GMII TX path between the ARP and UDP frame engines with round-robin grants,
// a registered output mux, a forced inter-frame gap and revocation of unused grants.
module eth_tx_arbiter
    import eth_tx_arbiter_pkg::*;
#(
    parameter int unsigned IFG_CYCLES    = IfgCyclesDefault,
    parameter int unsigned START_TIMEOUT = StartTimeoutDefault
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       arp_req,
    output logic       arp_gnt,
    input  logic       arp_tx_en,
    input  logic [7:0] arp_txd,
    input  logic       udp_req,
    output logic       udp_gnt,
    input  logic       udp_tx_en,
    input  logic [7:0] udp_txd,
    output logic       gmii_tx_en,
    output logic [7:0] gmii_txd,
    output logic       busy,
    output logic       timeout,
    output logic       collision
);

    localparam logic [15:0] TimeoutLast = 16'(START_TIMEOUT - 1);
    localparam logic [15:0] IfgLast     = 16'(IFG_CYCLES - 1);

    arb_state_e  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        last_q, last_d;
    logic [1:0]  gnt_q, gnt_d;
    logic        gmii_tx_en_q, gmii_tx_en_d;
    logic [7:0]  gmii_txd_q, gmii_txd_d;
    logic        busy_q, busy_d;
    logic        timeout_q, timeout_d;
    logic        collision_q, collision_d;

    logic [1:0]  arb_req;
    logic [1:0]  arb_gnt;
    logic        arb_win;
    logic        own_req, own_en, granted;
    logic [7:0]  own_txd;

    assign arb_req = {udp_req, arp_req};

    rr_arb2 u_rr_arb2 (
        .req_i  (arb_req),
        .last_i (last_q),
        .gnt_o  (arb_gnt),
        .win_o  (arb_win)
    );

    // The owner of an active grant is always the most recent winner.
    assign own_req = (last_q == ReqUdp) ? udp_req   : arp_req;
    assign own_en  = (last_q == ReqUdp) ? udp_tx_en : arp_tx_en;
    assign own_txd = (last_q == ReqUdp) ? udp_txd   : arp_txd;
    assign granted = (state_q == StGrant) || (state_q == StSend);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        timeout_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (arb_gnt != 2'b00) begin
                    state_d = StGrant;
                    last_d  = arb_win;
                end
            end
            StGrant: begin
                cnt_d = cnt_q + 16'd1;
                if (own_en) begin
                    state_d = StSend;
                end else if (!own_req) begin
                    state_d = StIdle;
                end else if (cnt_q == TimeoutLast) begin
                    state_d   = StIfg;
                    timeout_d = 1'b1;
                end
            end
            StSend: begin
                if (!own_en) begin
                    state_d = StIfg;
                end
            end
            StIfg: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == IfgLast) begin
                    if (arb_gnt != 2'b00) begin
                        state_d = StGrant;
                        last_d  = arb_win;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_d != state_q) begin
            cnt_d = 16'd0;
        end

        gnt_d        = ((state_d == StGrant) || (state_d == StSend)) ? idx_to_onehot(last_d)
                                                                       : 2'b00;
        gmii_tx_en_d = granted & own_en;
        gmii_txd_d   = granted ? own_txd : 8'h00;
        busy_d       = (state_d != StIdle);
        collision_d  = (arp_tx_en & ~gnt_q[ReqArp]) | (udp_tx_en & ~gnt_q[ReqUdp]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= 16'd0;
            last_q       <= ReqUdp;
            gnt_q        <= 2'b00;
            gmii_tx_en_q <= 1'b0;
            gmii_txd_q   <= 8'h00;
            busy_q       <= 1'b0;
            timeout_q    <= 1'b0;
            collision_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_q       <= last_d;
            gnt_q        <= gnt_d;
            gmii_tx_en_q <= gmii_tx_en_d;
            gmii_txd_q   <= gmii_txd_d;
            busy_q       <= busy_d;
            timeout_q    <= timeout_d;
            collision_q  <= collision_d;
        end
    end

    assign arp_gnt    = gnt_q[ReqArp];
    assign udp_gnt    = gnt_q[ReqUdp];
    assign gmii_tx_en = gmii_tx_en_q;
    assign gmii_txd   = gmii_txd_q;
    assign busy       = busy_q;
    assign timeout    = timeout_q;
    assign collision  = collision_q;

endmodule

// File: doc/eth_tx_arbiter.md
# eth_tx_arbiter

Shares the single GMII transmit path in front of the RGMII converter between two frame engines, the ARP transmitter and the UDP transmitter. Grants the path to one requester at a time with round-robin fairness and muxes that engine's `tx_en`/`txd` onto GMII with one register stage. Enforces a minimum inter-frame gap and releases grants that are never used. Runs in the GMII TX clock domain.

## Interface
Parameters:
- `IFG_CYCLES`, 12: idle cycles forced after each frame; legal range 1..65535.
- `START_TIMEOUT`, 1024: cycles a grant may go unused before it is revoked; legal range 1..65535.

Ports:
- `clk` in 1: GMII TX clock, 125 MHz; the only clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `arp_req` in 1: ARP engine frame request, level; held high until its frame ends.
- `arp_gnt` out 1: ARP engine owns the path.
- `arp_tx_en` in 1: ARP engine GMII enable.
- `arp_txd` in 8: ARP engine GMII data.
- `udp_req` in 1: UDP engine frame request, level.
- `udp_gnt` out 1: UDP engine owns the path.
- `udp_tx_en` in 1: UDP engine GMII enable.
- `udp_txd` in 8: UDP engine GMII data.
- `gmii_tx_en` out 1: to GMII/RGMII converter.
- `gmii_txd` out 8: to GMII/RGMII converter.
- `busy` out 1: high whenever state is not IDLE.
- `timeout` out 1: one-cycle pulse when a grant is revoked unused.
- `collision` out 1: one-cycle pulse, registered, when a non-granted engine drives `tx_en` high.

## Operation
States:
- IDLE
  - No request pending: stay in IDLE.
  - Any request pending: go to GRANT.
  - If only one engine requests, that engine wins.
  - If both request, the engine not served last wins.
  - `last` register resets to UDP, so ARP wins the first tie.
  - On grant, `last` updates to the winner.
- GRANT: winner's `gnt` is high; start counter runs from 0.
  - Winner's `tx_en` sampled high: go to SEND.
  - Winner's `req` drops, `tx_en` low: go to IDLE, no gap.
  - Counter reaches `START_TIMEOUT`-1: go to IFG and pulse `timeout`.
- SEND: forward the winner's data until its `tx_en` is sampled low, then go to IFG.
- IFG: counter runs from 0 to `IFG_CYCLES`-1, then:
  - any request pending: arbitrate as in IDLE and go straight to GRANT;
  - otherwise go to IDLE.

Rules:
- `gnt` is registered and one-hot or zero; high only in GRANT and SEND.
- `gmii_tx_en`/`gmii_txd` are registered.
  - While granted (GRANT/SEND): copy the winner's inputs.
  - Otherwise: 0 / 8'h00.
- Non-granted inputs never reach GMII.
- A `req` still high after IFG counts as a new frame request.
- Counter is 16 bits and shared between the GRANT timeout and the IFG count; it clears on every state change.
- `collision` is informational only; it does not change state.

## Timing
- Reset: all outputs 0, state IDLE, counter 0, `last` = UDP. Applies at the first edge with `rst_n` low, even mid-frame: `gmii_tx_en` drops that edge.
- Request sampled at edge n in IDLE → `gnt` high after edge n.
- Winner `tx_en`/`txd` sampled at edge m → on `gmii_*` after edge m (1-cycle latency, no bubbles, byte order preserved).
- `tx_en` sampled low at edge k:
  - after edge k: `gmii_tx_en` = 0, `gnt` = 0, state IFG;
  - after edge k+`IFG_CYCLES`: next `gnt` earliest;
  - gap on `gmii_tx_en` between frames ≥ `IFG_CYCLES`+1 cycles.
- Simultaneous `req` rise in IDLE: round-robin decides; the loser keeps `req` high and is served next.
- Winner `tx_en` high on the same edge its `req` drops: SEND takes precedence.
- `START_TIMEOUT`=1: grant lasts exactly one cycle if unused.

## Structure
- Shared header `eth_defs.vh` holds:
  - state encodings: IDLE=0, GRANT=1, SEND=2, IFG=3;
  - default `IFG_CYCLES` and `START_TIMEOUT` values;
  - requester index constants ARP=0, UDP=1.
- One sub-module, `rr_arb2`: combinational 2-way round-robin pick from `{req, last}` producing a one-hot winner. Everything else stays in `eth_tx_arbiter`.

## Test plan
- ARP-only request; ARP sends 60 bytes 8'h01..8'h3C → `arp_gnt` next cycle; `gmii_txd` carries the same 60 bytes delayed 1 cycle; `udp_gnt` stays 0.
- Both `req` rise together after reset → ARP first; after ARP frame end, UDP granted exactly 12 cycles after `gmii_tx_en` falls; `gmii_tx_en` low gap = 13 cycles.
- ARP held granted with no `tx_en`, `START_TIMEOUT`=16 → `timeout` pulses once after 16 grant cycles; `gmii_tx_en` never asserts; UDP request then served.
- UDP drives `udp_tx_en`=1, `udp_txd`=8'hFF while ARP is in SEND → `collision` pulses each such cycle; `gmii_txd` shows only ARP bytes.
- `rst_n` low for 1 cycle mid-SEND, byte 20 of 64 → `gmii_tx_en`, `gnt`, `busy` = 0 the next cycle; state IDLE; a re-asserted request is granted 1 cycle after `rst_n` returns high.
- Back-to-back frames from ARP alone, `req` held high → two frames with gap = `IFG_CYCLES`+1; ARP re-granted because no competitor.
